pe_array_sequencer: RTL and testbench
=====================================

# pe_array_sequencer

Sequencer for the Smith-Waterman systolic PE array and its max-reduction tree. It tiles a query (s) longer than the array into segments of up to N characters. For each segment it loads characters into the PEs, streams the full target (t) column through the array, drains the pipeline, and tracks which array-output beats are valid for write-back. After the last segment it waits out the max-tree latency and signals completion to the top-level controller.

## Interface
Parameters:
- N, 64, number of PEs in the array
- N_LOG, 6, bits for a PE index (log2 N)
- MAX_LAT, 6, max-tree latency in cycles (≥1)
- PASS_W, 16, pass-counter width

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset: asynchronous, active-high
- i_start  input  1  start pulse; ignored while o_busy
- o_busy  output  1  high from the cycle after the accepted i_start through the o_done cycle
- o_done  output  1  one-cycle pulse: final score is stable at the max tree
- o_max_init  output  1  one-cycle pulse clearing the max tree
- i_s_valid  input  1  query char available
- i_s  input  2  query char
- i_s_last  input  1  final query char
- o_s_ready  output  1  query char accepted when i_s_valid & o_s_ready
- o_pe_s_we  output  1  write o_pe_s into PE o_pe_s_idx
- o_pe_s_idx  output  N_LOG  PE index
- o_pe_s  output  2  char to load
- o_pe_enable  output  N  PE activity mask; bit N-1-k enables PE k
- i_t_valid  input  1  target char available
- i_t_last  input  1  final target char of the column
- o_t_ready  output  1  target char accepted when i_t_valid & o_t_ready
- o_pe_lock  output  1  freeze all PE registers this cycle
- o_newline  output  1  marks the first t beat of a pass into PE 0
- o_col_valid  output  1  array output (t/v/f) this cycle is a real beat
- o_pass  output  PASS_W  index of the current segment, 0-based

## Operation
- States: IDLE, LOAD_S, RUN, DRAIN, WAIT_MAX, DONE.

IDLE
- On i_start: go to LOAD_S.
- Clear o_pass, loaded_cnt and the enable mask.
- Pulse o_max_init in the next cycle.

LOAD_S
- o_s_ready = 1.
- Each accepted char k (k = 0, 1, …) is written to PE k.
- The enable mask gains bit N-1-k.
- The state exits to RUN when either:
  - the accepted char has i_s_last = 1 (last_seg is set), or
  - k = N-1.
- On exit, loaded_cnt = k+1.

RUN
- o_t_ready = 1.
- o_pe_lock = ~i_t_valid (combinational).
- o_newline = 1 on the first accepted t beat of the pass (combinational) and 0 otherwise.
- An accepted beat with i_t_last = 1 moves the state to DRAIN.

DRAIN
- o_t_ready = 0 and o_pe_lock = 0.
- The state lasts exactly loaded_cnt cycles.
- At the end:
  - If last_seg = 1, go to WAIT_MAX.
  - Otherwise go to LOAD_S with o_pass+1, loaded_cnt cleared and the mask cleared.

WAIT_MAX
- The state lasts MAX_LAT cycles, then goes to DONE.

DONE
- o_done = 1 for one cycle, then go to IDLE.

Output valid pipeline
- An N-bit shift register vp shifts in (RUN & i_t_valid) on every cycle where o_pe_lock = 0.
- o_col_valid = vp[loaded_cnt-1].

## Timing
- Reset values: all outputs 0, o_pe_enable = 0, o_pass = 0, state IDLE.
- Reset asserted mid-operation aborts immediately to IDLE. Partial loads are discarded.
- o_pe_s_we, o_pe_s_idx and o_pe_s are registered: they appear the cycle after acceptance. The enable bit is set in that same cycle.
- o_s_ready, o_t_ready, o_pe_lock and o_newline are combinational from state and inputs.
- o_busy, o_done, o_max_init and o_pass are registered.
- Start latency: i_start at cycle c gives o_busy = 1 and o_max_init = 1 at c+1, with o_s_ready = 1 at c+1.
- An i_s beat accepted at cycle c drives o_pe_s_we at c+1.
- o_col_valid for a t beat accepted at cycle c rises loaded_cnt non-locked cycles later.
- Stalls: when i_t_valid = 0 in RUN, the array and vp freeze and no beat is lost.
- o_newline survives stalls: it stays pending until the first accepted beat.
- Boundaries:
  - i_s_last on the first char gives loaded_cnt = 1 and a one-cycle DRAIN.
  - Exactly N chars with i_s_last gives a single pass.
  - N chars without i_s_last give another pass.
  - i_t_last on the first beat is legal: a one-beat pass.
  - o_pass wraps modulo 2^PASS_W with no error.
  - i_start in any state other than IDLE is ignored.

## Test plan
- Reset mid-RUN (rst asserted during beat 3) -> next cycle: all outputs 0 and state IDLE; a subsequent i_start behaves normally.
- N=64, 10 s chars (last on 10th), 20 t beats without stalls -> o_pe_s_we 10 times with idx 0..9; o_pe_enable = 0xFFC0_0000_0000_0000; o_newline on beat 1 only; o_col_valid exactly 20 cycles starting 10 cycles after the first beat; DRAIN of 10 cycles; o_done 6 cycles after DRAIN ends.
- 130 s chars, 5 t beats per pass -> three passes with o_pass 0, 1, 2 and loaded_cnt 64, 64, 2; o_max_init pulsed once only; single o_done.
- Random i_t_valid gaps (50% duty) -> o_pe_lock equals ~i_t_valid in RUN; count of o_col_valid equals count of accepted beats; o_newline attached to the first accepted beat.
- Single s char and a single t beat with i_s_last = i_t_last = 1 -> one-cycle DRAIN; one o_col_valid one cycle after acceptance; o_done after MAX_LAT.
- i_start pulsed during LOAD_S and RUN -> ignored; o_pass and the counters are undisturbed.

Source files
------------

// File: rtl/pe_array_sequencer.sv
// Segment sequencer for the Smith-Waterman PE array: tiles the query over
// N PEs, streams the target column per segment and waits out the max tree.
module pe_array_sequencer #(
    parameter int N       = 64,
    parameter int N_LOG   = 6,
    parameter int MAX_LAT = 6,
    parameter int PASS_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_max_init,
    input  logic              i_s_valid,
    input  logic [1:0]        i_s,
    input  logic              i_s_last,
    output logic              o_s_ready,
    output logic              o_pe_s_we,
    output logic [N_LOG-1:0]  o_pe_s_idx,
    output logic [1:0]        o_pe_s,
    output logic [N-1:0]      o_pe_enable,
    input  logic              i_t_valid,
    input  logic              i_t_last,
    output logic              o_t_ready,
    output logic              o_pe_lock,
    output logic              o_newline,
    output logic              o_col_valid,
    output logic [PASS_W-1:0] o_pass
);

    localparam int LW = N_LOG + 1;
    localparam int WW = $clog2(MAX_LAT) + 1;

    typedef enum logic [2:0] {
        IDLE, LOAD_S, RUN, DRAIN, WAIT_MAX, DONE
    } state_t;

    state_t state, state_nx;

    logic [LW-1:0]    loaded_cnt;
    logic [LW-1:0]    drain_cnt;
    logic [WW-1:0]    wait_cnt;
    logic             last_seg;
    logic             nl_pend;
    logic [N-1:0]     vp;
    logic             start_acc;
    logic             s_acc;
    logic             t_acc;
    logic             load_end;
    logic             drain_end;
    logic             wait_end;
    logic             next_seg;
    logic [N_LOG-1:0] vp_sel;
    logic [N_LOG-1:0] mask_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        o_s_ready   = 1'b0;
        o_t_ready   = 1'b0;
        o_pe_lock   = 1'b0;
        o_newline   = 1'b0;
        start_acc   = 1'b0;
        s_acc       = 1'b0;
        t_acc       = 1'b0;
        load_end    = 1'b0;
        drain_end   = 1'b0;
        wait_end    = 1'b0;
        unique case (state)
            IDLE: begin
                start_acc = i_start;
                if (i_start) state_nx = LOAD_S;
            end
            LOAD_S: begin
                o_s_ready = 1'b1;
                s_acc     = i_s_valid;
                load_end  = s_acc & (i_s_last | (loaded_cnt == LW'(N - 1)));
                if (load_end) state_nx = RUN;
            end
            RUN: begin
                o_t_ready = 1'b1;
                o_pe_lock = ~i_t_valid;
                t_acc     = i_t_valid;
                o_newline = nl_pend & i_t_valid;
                if (t_acc & i_t_last) state_nx = DRAIN;
            end
            DRAIN: begin
                drain_end = (drain_cnt == loaded_cnt - LW'(1));
                if (drain_end) state_nx = last_seg ? WAIT_MAX : LOAD_S;
            end
            WAIT_MAX: begin
                wait_end = (wait_cnt == WW'(MAX_LAT - 1));
                if (wait_end) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        next_seg    = drain_end & ~last_seg;
        vp_sel      = loaded_cnt[N_LOG-1:0] - N_LOG'(1);
        mask_idx    = N_LOG'(N - 1) - loaded_cnt[N_LOG-1:0];
        // A frozen array repeats its output, so locked cycles carry no beat
        o_col_valid = (loaded_cnt != '0) & vp[vp_sel] & ~o_pe_lock;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_pe_s_we   <= 1'b0;
            o_pe_s_idx  <= '0;
            o_pe_s      <= '0;
            o_pe_enable <= '0;
            o_pass      <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_max_init  <= 1'b0;
            loaded_cnt  <= '0;
            drain_cnt   <= '0;
            wait_cnt    <= '0;
            last_seg    <= 1'b0;
            nl_pend     <= 1'b0;
            vp          <= '0;
        end else begin
            o_pe_s_we  <= s_acc;
            o_max_init <= start_acc;
            o_done     <= wait_end;
            if (s_acc) begin
                o_pe_s_idx <= loaded_cnt[N_LOG-1:0];
                o_pe_s     <= i_s;
            end
            if (start_acc | next_seg) begin
                o_pe_enable <= '0;
                loaded_cnt  <= '0;
            end else if (s_acc) begin
                o_pe_enable[mask_idx] <= 1'b1;
                loaded_cnt            <= loaded_cnt + LW'(1);
            end
            if (start_acc)               last_seg <= 1'b0;
            else if (s_acc & i_s_last)   last_seg <= 1'b1;
            if (start_acc)     o_pass <= '0;
            else if (next_seg) o_pass <= o_pass + PASS_W'(1);
            if (load_end)   nl_pend <= 1'b1;
            else if (t_acc) nl_pend <= 1'b0;
            if (state == DRAIN && !drain_end) drain_cnt <= drain_cnt + LW'(1);
            else                              drain_cnt <= '0;
            if (state == WAIT_MAX && !wait_end) wait_cnt <= wait_cnt + WW'(1);
            else                                wait_cnt <= '0;
            if (start_acc)       vp <= '0;
            else if (!o_pe_lock) vp <= {vp[N-2:0], t_acc};
            if (start_acc)          o_busy <= 1'b1;
            else if (state == DONE) o_busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Scoreboard bench for pe_array_sequencer: PE loads and column-valid
// timing are predicted at stimulus time and retired as the DUT emits them.
module tb_pe_array_sequencer;

    localparam int N       = 64;
    localparam int N_LOG   = 6;
    localparam int MAX_LAT = 6;
    localparam int PASS_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_start = 1'b0;
    logic              o_busy, o_done, o_max_init;
    logic              i_s_valid = 1'b0;
    logic [1:0]        i_s = '0;
    logic              i_s_last = 1'b0;
    logic              o_s_ready, o_pe_s_we;
    logic [N_LOG-1:0]  o_pe_s_idx;
    logic [1:0]        o_pe_s;
    logic [N-1:0]      o_pe_enable;
    logic              i_t_valid = 1'b0;
    logic              i_t_last = 1'b0;
    logic              o_t_ready, o_pe_lock, o_newline, o_col_valid;
    logic [PASS_W-1:0] o_pass;

    always #5 clk = ~clk;

    pe_array_sequencer #(
        .N(N), .N_LOG(N_LOG), .MAX_LAT(MAX_LAT), .PASS_W(PASS_W)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done), .o_max_init(o_max_init),
        .i_s_valid(i_s_valid), .i_s(i_s), .i_s_last(i_s_last),
        .o_s_ready(o_s_ready), .o_pe_s_we(o_pe_s_we),
        .o_pe_s_idx(o_pe_s_idx), .o_pe_s(o_pe_s),
        .o_pe_enable(o_pe_enable), .i_t_valid(i_t_valid),
        .i_t_last(i_t_last), .o_t_ready(o_t_ready),
        .o_pe_lock(o_pe_lock), .o_newline(o_newline),
        .o_col_valid(o_col_valid), .o_pass(o_pass)
    );

    typedef struct {
        int idx;
        int ch;
        int pass;
    } pe_wr_t;

    pe_wr_t sq[$];
    int     cq[$];
    pe_wr_t mon_e;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ulc = 0;
    logic lock_s = 1'b0;
    int   max_init_cnt = 0;
    int   done_cnt = 0;
    int   last_cv = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic report();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    endtask

    task automatic bail(input string tag);
        check(tag, 64'd0, 64'd1);
        report();
    endtask

    function automatic logic [63:0] top_mask(input int len);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < len; i++) m[63-i] = 1'b1;
        return m;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {o_busy, o_done, o_max_init, o_s_ready,
              o_t_ready, o_pe_lock, o_newline, o_col_valid, o_pe_s_we}, 0);
        check({tag, "_enable"}, o_pe_enable, 0);
        check({tag, "_pass"}, o_pass, 0);
        check({tag, "_pe_s"}, {o_pe_s_idx, o_pe_s}, 0);
    endtask

    // ulc counts unlocked cycles: the array's notion of time
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!lock_s) ulc <= ulc + 1;
    end

    always @(negedge clk) begin
        lock_s = o_pe_lock;
        if (o_pe_s_we) begin
            if (sq.size() == 0) check("pe_we_unexpected", 1, 0);
            else begin
                mon_e = sq.pop_front();
                check("pe_idx", o_pe_s_idx, mon_e.idx);
                check("pe_char", o_pe_s, mon_e.ch);
                check("pe_pass", o_pass, mon_e.pass);
            end
        end
        if (o_col_valid) begin
            last_cv = cyc;
            if (cq.size() == 0) check("col_unexpected", 1, 0);
            else check("col_time", ulc, cq.pop_front());
        end
        if (o_t_ready) check("lock", o_pe_lock, !i_t_valid);
        if (o_max_init) max_init_cnt++;
        if (o_done) done_cnt++;
    end

    task automatic run_job(input int ns, input int nt, input bit gaps,
                           input bit poke, input int rst_beat);
        int rem, len, prev_len, p, lb, t0, w, g;
        pe_wr_t e;
        max_init_cnt = 0;
        done_cnt = 0;
        rem = ns;
        p = 0;
        lb = 0;
        len = 0;
        prev_len = 0;
        i_start = 1'b1;
        @(negedge clk);
        t0 = cyc;
        @(posedge clk); #1;
        i_start = 1'b0;
        while (rem > 0) begin
            len = (rem > N) ? N : rem;
            for (int k = 0; k < len; k++) begin
                i_s_valid = 1'b1;
                i_s = 2'($urandom_range(0, 3));
                i_s_last = (k == rem - 1);
                if (poke && k == 1) i_start = 1'b1;
                w = 0;
                @(negedge clk);
                while (!o_s_ready && w < 300) begin
                    @(negedge clk);
                    w++;
                end
                if (!o_s_ready) bail("s_ready_timeout");
                e.idx = k;
                e.ch = int'(i_s);
                e.pass = p;
                sq.push_back(e);
                if (k == 0 && p == 0) begin
                    check("start_latency", cyc - t0, 1);
                    check("start_busy", o_busy, 1);
                    check("start_max_init", o_max_init, 1);
                end
                if (k == 0 && p > 0) check("drain_len", cyc - lb, prev_len + 1);
                @(posedge clk); #1;
                i_start = 1'b0;
            end
            i_s_valid = 1'b0;
            i_s_last = 1'b0;
            @(negedge clk);
            check("enable_mask", o_pe_enable, top_mask(len));
            check("pass_idx", o_pass, p);
            for (int b = 0; b < nt; b++) begin
                @(posedge clk); #1;
                i_start = 1'b0;
                if (gaps) begin
                    g = $urandom_range(0, 3);
                    repeat (g) begin
                        i_t_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                end
                i_t_valid = 1'b1;
                i_t_last = (b == nt - 1);
                if (poke && b == 1) i_start = 1'b1;
                w = 0;
                @(negedge clk);
                while (!o_t_ready && w < 300) begin
                    @(negedge clk);
                    w++;
                end
                if (!o_t_ready) bail("t_ready_timeout");
                check("newline", o_newline, b == 0);
                cq.push_back(ulc + len);
                lb = cyc;
                if (b == rst_beat) begin
                    #2;
                    rst = 1'b1;
                    i_t_valid = 1'b0;
                    i_t_last = 1'b0;
                    i_start = 1'b0;
                    sq.delete();
                    cq.delete();
                    @(negedge clk);
                    check_zero("mid_reset");
                    @(posedge clk); #1;
                    rst = 1'b0;
                    return;
                end
            end
            @(posedge clk); #1;
            i_t_valid = 1'b0;
            i_t_last = 1'b0;
            i_start = 1'b0;
            prev_len = len;
            rem -= len;
            p++;
        end
        w = 0;
        @(negedge clk);
        while (!o_done && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!o_done) bail("done_timeout");
        check("done_time", cyc - lb, len + MAX_LAT + 1);
        check("done_busy", o_busy, 1);
        check("last_col", last_cv - lb, len);
        @(negedge clk);
        check("idle_busy", o_busy, 0);
        check("done_once", done_cnt, 1);
        check("max_init_once", max_init_cnt, 1);
        check("col_drained", cq.size(), 0);
        check("pe_drained", sq.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        run_job(4, 8, 1'b0, 1'b0, 2);
        run_job(4, 6, 1'b0, 1'b0, -1);
        run_job(10, 20, 1'b0, 1'b0, -1);
        run_job(130, 5, 1'b0, 1'b1, -1);
        run_job(40, 30, 1'b1, 1'b0, -1);
        run_job(1, 1, 1'b0, 1'b0, -1);
        run_job(64, 3, 1'b1, 1'b0, -1);
        report();
    end

    initial begin
        #500000;
        bail("global_timeout");
    end

endmodule
